// File: rtl/usb_fs_ep_pkg.sv
// Shared types and helpers for the full-speed IN stream endpoint.
package usb_fs_ep_pkg;

    // Packetizer states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReq     = 3'd1,
        StXfer    = 3'd2,
        StDone    = 3'd3,
        StWaitAck = 3'd4
    } ep_state_e;

    // Width of the SOF counter; holds FLUSH_SOFS up to 15.
    localparam int unsigned SofCntW = 4;

    // Bits needed to hold a counter that runs from 0 up to and including max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/usb_byte_fifo.sv
// Single-clock byte FIFO with occupancy output and first-word fall-through read data.
module usb_byte_fifo #(
    parameter int unsigned DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_ok, rd_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and level next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ok    = wr_en & ~full;
        rd_ok    = rd_en & (level_q != '0);
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (wr_ok && !rd_ok) begin
            level_d = level_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointer and level registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/usb_fs_in_stream_ep.sv
// Byte-stream IN endpoint: buffers application bytes, frames them into packets of up to
// MAX_PKT bytes and feeds the protocol engine IN port one byte every other cycle.
// Optional zero-length packet after a full final packet: define USB_IN_EP_ZLP_EN.
module usb_fs_in_stream_ep #(
    parameter int unsigned MAX_PKT    = 64,
    parameter int unsigned FIFO_DEPTH = 128,
    parameter int unsigned FLUSH_SOFS = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    app_data,
    input  logic                          app_valid,
    output logic                          app_ready,
    input  logic                          sof_valid,
    output logic                          in_ep_req,
    input  logic                          in_ep_grant,
    input  logic                          in_ep_data_free,
    output logic                          in_ep_data_put,
    output logic [7:0]                    in_ep_data,
    output logic                          in_ep_data_done,
    output logic                          in_ep_stall,
    input  logic                          in_ep_acked,
    input  logic                          stall_cfg,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import usb_fs_ep_pkg::*;

    localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PktW = cnt_width(MAX_PKT);
    localparam logic [LvlW-1:0]    MaxPktLvl = LvlW'(MAX_PKT);
    localparam logic [PktW-1:0]    MaxPktLen = PktW'(MAX_PKT);
    localparam logic [SofCntW-1:0] FlushCnt  = SofCntW'(FLUSH_SOFS);

    ep_state_e            state_q, state_d;
    logic [PktW-1:0]      pkt_len_q, pkt_len_d;
    logic [PktW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [SofCntW-1:0]   sof_cnt_q, sof_cnt_d;
    logic                 put_q, put_d;
    logic                 done_q, done_d;
    logic [7:0]           data_q, data_d;

    logic                 push, pop;
    logic                 fifo_full;
    logic [7:0]           fifo_rd_data;
    logic                 level_nz, level_pkt;
    logic                 zlp_armed;
    logic [PktW-1:0]      launch_len;

    assign app_ready = reset_n & ~fifo_full;
    assign push      = app_valid & app_ready;

    usb_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data (app_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full)
    );

    assign level_nz   = (fifo_level != '0);
    assign level_pkt  = (fifo_level >= MaxPktLvl);
    assign launch_len = level_pkt ? MaxPktLen : PktW'(fifo_level);

`ifdef USB_IN_EP_ZLP_EN
    logic last_full_q, last_full_d;
    // An empty FIFO after a full-size packet keeps SOF counting alive for the ZLP.
    assign zlp_armed = last_full_q & ~level_nz;
`else
    assign zlp_armed = 1'b0;
`endif

    assign in_ep_req       = (state_q != StIdle);
    assign in_ep_data_put  = put_q;
    assign in_ep_data      = data_q;
    assign in_ep_data_done = done_q;
    assign in_ep_stall     = stall_cfg;

    // Packetizer next-state, SOF flush counter and PE-side strobes.
    always_comb begin
        state_d    = state_q;
        pkt_len_d  = pkt_len_q;
        byte_cnt_d = byte_cnt_q;
        sof_cnt_d  = sof_cnt_q;
        put_d      = 1'b0;
        done_d     = 1'b0;
        data_d     = data_q;
        pop        = 1'b0;
`ifdef USB_IN_EP_ZLP_EN
        last_full_d = last_full_q;
`endif

        if (!level_nz && !zlp_armed) begin
            sof_cnt_d = '0;
        end else if (state_q == StIdle && sof_valid && sof_cnt_q != FlushCnt &&
                     ((level_nz && !level_pkt) || zlp_armed)) begin
            sof_cnt_d = sof_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (level_pkt || (level_nz && sof_cnt_q == FlushCnt)) begin
                    state_d    = StReq;
                    pkt_len_d  = launch_len;
                    byte_cnt_d = '0;
                    sof_cnt_d  = '0;
                end else if (zlp_armed && sof_cnt_q == FlushCnt) begin
                    state_d    = StReq;
                    pkt_len_d  = '0;
                    byte_cnt_d = '0;
                    sof_cnt_d  = '0;
                end
            end
            StReq: begin
                if (in_ep_grant) begin
                    // A zero-length packet skips the byte phase entirely.
                    if (pkt_len_q == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StXfer;
                    end
                end
            end
            StXfer: begin
                if (in_ep_grant) begin
                    if (byte_cnt_q == pkt_len_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (in_ep_data_free && !put_q) begin
                        pop        = 1'b1;
                        put_d      = 1'b1;
                        data_d     = fifo_rd_data;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StWaitAck;
`ifdef USB_IN_EP_ZLP_EN
                last_full_d = (pkt_len_q == MaxPktLen);
`endif
            end
            StWaitAck: begin
                if (in_ep_grant && in_ep_acked) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef USB_IN_EP_ZLP_EN
        // Fresh data means the stream continues, so no ZLP terminator is owed.
        if (push) begin
            last_full_d = 1'b0;
        end
`endif
    end

    // Packetizer state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pkt_len_q  <= '0;
            byte_cnt_q <= '0;
            sof_cnt_q  <= '0;
            put_q      <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            pkt_len_q  <= pkt_len_d;
            byte_cnt_q <= byte_cnt_d;
            sof_cnt_q  <= sof_cnt_d;
            put_q      <= put_d;
            done_q     <= done_d;
            data_q     <= data_d;
        end
    end

`ifdef USB_IN_EP_ZLP_EN
    // Remembers whether the last packet sent was full size.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_full_q <= 1'b0;
        end else begin
            last_full_q <= last_full_d;
        end
    end
`endif

endmodule

// File: tb/tb_usb_fs_in_stream_ep.sv
// Self-checking bench for usb_fs_in_stream_ep (default parameters).
module tb_usb_fs_in_stream_ep;

    localparam int MAX_PKT    = 64;
    localparam int FIFO_DEPTH = 128;
    localparam int FLUSH_SOFS = 2;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic             clk;
    logic             reset_n;
    logic [7:0]       app_data;
    logic             app_valid;
    logic             app_ready;
    logic             sof_valid;
    logic             in_ep_req;
    logic             in_ep_grant;
    logic             in_ep_data_free;
    logic             in_ep_data_put;
    logic [7:0]       in_ep_data;
    logic             in_ep_data_done;
    logic             in_ep_stall;
    logic             in_ep_acked;
    logic             stall_cfg;
    logic [LVL_W-1:0] fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference stream (bytes accepted by the FIFO) and observed PE traffic.
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         size_q[$];
    int         cur_cnt, order_err, req_err, gap_min, gap_max, last_put_cyc, cyc;
    bit         pending_ack;

    usb_fs_in_stream_ep #(
        .MAX_PKT    (MAX_PKT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FLUSH_SOFS (FLUSH_SOFS)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .app_data        (app_data),
        .app_valid       (app_valid),
        .app_ready       (app_ready),
        .sof_valid       (sof_valid),
        .in_ep_req       (in_ep_req),
        .in_ep_grant     (in_ep_grant),
        .in_ep_data_free (in_ep_data_free),
        .in_ep_data_put  (in_ep_data_put),
        .in_ep_data      (in_ep_data),
        .in_ep_data_done (in_ep_data_done),
        .in_ep_stall     (in_ep_stall),
        .in_ep_acked     (in_ep_acked),
        .stall_cfg       (stall_cfg),
        .fifo_level      (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Passive monitor on the falling edge: records puts, packet sizes and protocol slips.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                cur_cnt     = 0;
                pending_ack = 1'b0;
            end else begin
                if (in_ep_data_put) begin
                    obs_q.push_back(in_ep_data);
                    if (cur_cnt > 0) begin
                        if (cyc - last_put_cyc < gap_min) gap_min = cyc - last_put_cyc;
                        if (cyc - last_put_cyc > gap_max) gap_max = cyc - last_put_cyc;
                    end
                    last_put_cyc = cyc;
                    cur_cnt++;
                    if (pending_ack) order_err++;
                end
                if (in_ep_data_done) begin
                    size_q.push_back(cur_cnt);
                    cur_cnt     = 0;
                    pending_ack = 1'b1;
                end else if (pending_ack && !in_ep_req) begin
                    req_err++;
                end
                if (in_ep_acked && in_ep_grant && pending_ack) pending_ack = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        exp_q.delete();
        obs_q.delete();
        size_q.delete();
        order_err = 0;
        req_err   = 0;
        gap_min   = 1000;
        gap_max   = 0;
    endtask

    // Number of positions where the observed stream differs from the reference stream.
    function automatic int stream_diff();
        int d = (obs_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) d++;
        end
        return d;
    endfunction

    // Push n bytes back-to-back; incrementing pattern from start, or random.
    task automatic push_bytes(input int n, input bit inc, input logic [7:0] start);
        logic [7:0] b;
        int budget;
        for (int i = 0; i < n; i++) begin
            b = inc ? 8'(int'(start) + i) : 8'($urandom);
            app_data  = b;
            app_valid = 1'b1;
            budget    = 2000;
            while (!app_ready && budget > 0) begin
                tick(1);
                budget--;
            end
            if (budget == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL push_timeout: app_ready stuck low, byte %0d required to be accepted", i);
                app_valid = 1'b0;
                return;
            end
            tick(1);
            exp_q.push_back(b);
        end
        app_valid = 1'b0;
    endtask

    task automatic sof_pulse();
        sof_valid = 1'b1;
        tick(1);
        sof_valid = 1'b0;
        tick(2);
    endtask

    // Act as arbiter and protocol engine until n packets have been acked.
    task automatic serve(input int n, input bit rnd);
        int acks     = 0;
        int budget   = 5000;
        int ack_wait = -1;
        while (acks < n && budget > 0) begin
            in_ep_acked     = 1'b0;
            in_ep_grant     = in_ep_req && (!rnd || $urandom_range(0, 7) != 0);
            in_ep_data_free = !rnd || $urandom_range(0, 3) != 0;
            if (in_ep_data_done) begin
                ack_wait = rnd ? int'($urandom_range(1, 6)) : 1;
            end else if (ack_wait > 0) begin
                ack_wait--;
                if (ack_wait == 0) begin
                    in_ep_acked = 1'b1;
                    in_ep_grant = 1'b1;
                    ack_wait    = -1;
                    acks++;
                end
            end
            tick(1);
            budget--;
        end
        in_ep_acked     = 1'b0;
        in_ep_grant     = 1'b0;
        in_ep_data_free = 1'b1;
        if (budget == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL serve_timeout: acked %0d packets, required %0d", acks, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        n_tests++;
        if (app_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_app_ready: got %b required 0", app_ready);
        end
        n_tests++;
        if ({in_ep_req, in_ep_data_put, in_ep_data_done} !== 3'b000 || int'(fifo_level) !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: req/put/done=%b%b%b level=%0d required 000 level 0",
                     in_ep_req, in_ep_data_put, in_ep_data_done, fifo_level);
        end
        reset_n = 1'b1;
        tick(1);
        n_tests++;
        if (app_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_app_ready: got %b required 1", app_ready);
        end
        stall_cfg = 1'b1;
        #1;
        n_tests++;
        if (in_ep_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_passthru: got %b required 1", in_ep_stall);
        end
        stall_cfg = 1'b0;
        #1;
        n_tests++;
        if (in_ep_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got %b required 0", in_ep_stall);
        end
    endtask

    task automatic test_full_packet();
        int got;
        clear_stats();
        push_bytes(64, 1'b1, 8'h00);
        serve(1, 1'b0);
        got = (size_q.size() == 1) ? size_q[0] : -1;
        n_tests++;
        if (got !== 64) begin
            n_fail++;
            $display("FAIL full_pkt_size: got %0d (packets %0d) required 64", got, size_q.size());
        end
        n_tests++;
        if (stream_diff() !== 0) begin
            n_fail++;
            $display("FAIL full_pkt_data: %0d mismatches, %0d bytes seen, 64 required", stream_diff(), obs_q.size());
        end
        n_tests++;
        if (gap_min !== 2 || gap_max !== 2) begin
            n_fail++;
            $display("FAIL full_pkt_spacing: gap min %0d max %0d required 2/2", gap_min, gap_max);
        end
        n_tests++;
        if (req_err !== 0) begin
            n_fail++;
            $display("FAIL full_pkt_req_hold: %0d cycles req low before ack, required 0", req_err);
        end
        tick(1);
        n_tests++;
        if (in_ep_req !== 1'b0 || int'(fifo_level) !== 0) begin
            n_fail++;
            $display("FAIL full_pkt_idle: req %b level %0d required 0/0", in_ep_req, fifo_level);
        end
    endtask

    task automatic test_sof_flush();
        int got;
        clear_stats();
        push_bytes(5, 1'b0, 8'h00);
        tick(5);
        n_tests++;
        if (in_ep_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_sof: req %b required 0", in_ep_req);
        end
        sof_pulse();
        tick(4);
        n_tests++;
        if (in_ep_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_one_sof: req %b required 0", in_ep_req);
        end
        sof_pulse();
        tick(2);
        n_tests++;
        if (in_ep_req !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_two_sof: req %b required 1", in_ep_req);
        end
        serve(1, 1'b1);
        got = (size_q.size() == 1) ? size_q[0] : -1;
        n_tests++;
        if (got !== 5 || stream_diff() !== 0) begin
            n_fail++;
            $display("FAIL flush_pkt: size %0d diffs %0d required size 5 diffs 0", got, stream_diff());
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        in_ep_grant = 1'b0;
        push_bytes(128, 1'b0, 8'h00);
        n_tests++;
        if (app_ready !== 1'b0 || int'(fifo_level) !== 128) begin
            n_fail++;
            $display("FAIL b2b_full: app_ready %b level %0d required 0/128", app_ready, fifo_level);
        end
        fork
            push_bytes(2, 1'b0, 8'h00);
            serve(2, 1'b0);
        join
        n_tests++;
        if (size_q.size() !== 2 || order_err !== 0) begin
            n_fail++;
            $display("FAIL b2b_two_pkts: packets %0d early puts %0d required 2/0", size_q.size(), order_err);
        end else begin
            n_tests++;
            if (size_q[0] !== 64 || size_q[1] !== 64) begin
                n_fail++;
                $display("FAIL b2b_sizes: got %0d,%0d required 64,64", size_q[0], size_q[1]);
            end
        end
        tick(5);
        sof_pulse();
        tick(3);
        n_tests++;
        if (in_ep_req !== 1'b0 || int'(fifo_level) !== 2) begin
            n_fail++;
            $display("FAIL b2b_rest_wait: req %b level %0d required 0/2", in_ep_req, fifo_level);
        end
        sof_pulse();
        tick(2);
        serve(1, 1'b0);
        n_tests++;
        if (size_q.size() !== 3 || stream_diff() !== 0) begin
            n_fail++;
            $display("FAIL b2b_rest_flush: packets %0d diffs %0d required 3/0", size_q.size(), stream_diff());
        end else begin
            n_tests++;
            if (size_q[2] !== 2) begin
                n_fail++;
                $display("FAIL b2b_rest_size: got %0d required 2", size_q[2]);
            end
        end
    endtask

    task automatic test_pause();
        int snap;
        int budget = 1000;
        clear_stats();
        push_bytes(64, 1'b0, 8'h00);
        while (obs_q.size() < 15 && budget > 0) begin
            in_ep_grant     = in_ep_req;
            in_ep_data_free = 1'b1;
            tick(1);
            budget--;
        end
        in_ep_data_free = 1'b0;
        tick(1);
        snap = obs_q.size();
        tick(9);
        n_tests++;
        if (obs_q.size() !== snap) begin
            n_fail++;
            $display("FAIL pause_free: %0d puts while free low, required 0", obs_q.size() - snap);
        end
        in_ep_data_free = 1'b1;
        in_ep_grant     = 1'b0;
        tick(1);
        snap = obs_q.size();
        tick(2);
        n_tests++;
        if (obs_q.size() !== snap || in_ep_req !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_grant: %0d puts, req %b while grant low, required 0 puts req 1",
                     obs_q.size() - snap, in_ep_req);
        end
        serve(1, 1'b0);
        n_tests++;
        if (size_q.size() !== 1 || stream_diff() !== 0) begin
            n_fail++;
            $display("FAIL pause_pkt: packets %0d diffs %0d bytes %0d required 1/0/64",
                     size_q.size(), stream_diff(), obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int d = 0;
        int budget = 1000;
        clear_stats();
        push_bytes(64, 1'b1, 8'h40);
        while (obs_q.size() < 20 && budget > 0) begin
            in_ep_grant     = in_ep_req;
            in_ep_data_free = 1'b1;
            tick(1);
            budget--;
        end
        reset_n = 1'b0;
        tick(1);
        n_tests++;
        if ({in_ep_req, in_ep_data_put, in_ep_data_done, app_ready} !== 4'b0000 || int'(fifo_level) !== 0) begin
            n_fail++;
            $display("FAIL midreset_outputs: req/put/done/ready=%b%b%b%b level %0d required 0000/0",
                     in_ep_req, in_ep_data_put, in_ep_data_done, app_ready, fifo_level);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) d++;
        end
        n_tests++;
        if (d !== 0 || obs_q.size() < 20) begin
            n_fail++;
            $display("FAIL midreset_prefix: %0d diffs over %0d bytes, required 0 over >=20", d, obs_q.size());
        end
        reset_n     = 1'b1;
        in_ep_grant = 1'b0;
        tick(4);
        n_tests++;
        if (size_q.size() !== 0 || in_ep_req !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done: done pulses %0d req %b required 0/0", size_q.size(), in_ep_req);
        end
    endtask

    task automatic test_random();
        int n, nfull, rem, bad;
        int exp_sizes[$];
        for (int it = 0; it < 6; it++) begin
            clear_stats();
            exp_sizes.delete();
            n     = int'($urandom_range(1, 128));
            nfull = n / MAX_PKT;
            rem   = n % MAX_PKT;
            for (int k = 0; k < nfull; k++) exp_sizes.push_back(MAX_PKT);
            if (rem > 0) exp_sizes.push_back(rem);
            push_bytes(n, 1'b0, 8'h00);
            if (nfull > 0) serve(nfull, 1'b1);
            if (rem > 0) begin
                repeat (FLUSH_SOFS) sof_pulse();
                tick(2);
                serve(1, 1'b1);
            end
            bad = (size_q.size() != exp_sizes.size()) ? 1 : 0;
            for (int k = 0; k < size_q.size() && k < exp_sizes.size(); k++) begin
                if (size_q[k] != exp_sizes[k]) bad++;
            end
            n_tests++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL rand_sizes: iter %0d n=%0d got %0d packets, required %0d", it, n,
                         size_q.size(), exp_sizes.size());
            end
            n_tests++;
            if (stream_diff() !== 0 || order_err !== 0 || req_err !== 0 || gap_min < 2) begin
                n_fail++;
                $display("FAIL rand_stream: iter %0d diffs %0d early %0d reqdrop %0d mingap %0d required 0/0/0/>=2",
                         it, stream_diff(), order_err, req_err, gap_min);
            end
        end
    endtask

    task automatic test_zlp();
        clear_stats();
        push_bytes(64, 1'b0, 8'h00);
        serve(1, 1'b0);
        repeat (FLUSH_SOFS) sof_pulse();
        tick(3);
`ifdef USB_IN_EP_ZLP_EN
        n_tests++;
        if (in_ep_req !== 1'b1) begin
            n_fail++;
            $display("FAIL zlp_req: req %b required 1", in_ep_req);
        end
        serve(1, 1'b0);
        n_tests++;
        if (size_q.size() !== 2) begin
            n_fail++;
            $display("FAIL zlp_count: packets %0d required 2", size_q.size());
        end else begin
            n_tests++;
            if (size_q[0] !== 64 || size_q[1] !== 0) begin
                n_fail++;
                $display("FAIL zlp_sizes: got %0d,%0d required 64,0", size_q[0], size_q[1]);
            end
        end
`else
        n_tests++;
        if (in_ep_req !== 1'b0 || size_q.size() !== 1) begin
            n_fail++;
            $display("FAIL no_zlp: req %b packets %0d required 0/1", in_ep_req, size_q.size());
        end
`endif
        n_tests++;
        if (stream_diff() !== 0) begin
            n_fail++;
            $display("FAIL zlp_data: %0d diffs required 0", stream_diff());
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        app_data        = 8'h00;
        app_valid       = 1'b0;
        sof_valid       = 1'b0;
        in_ep_grant     = 1'b0;
        in_ep_data_free = 1'b1;
        in_ep_acked     = 1'b0;
        stall_cfg       = 1'b0;
        clear_stats();
        test_reset();
        test_full_packet();
        test_sof_flush();
        test_back_to_back();
        test_pause();
        test_reset_mid();
        test_random();
        test_zlp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
